dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port (dmem) between the pipelined RV32I core (M stage)
//  and a secondary bus master (DMA/program loader) using a valid/ready handshake.
//  The CPU has priority. A starvation counter forces one DMA transfer after MAX_WAIT
//  blocked cycles, and the CPU is stalled for that cycle.
//  Sits between rv32ipipelined/DMA and dmem inside top.
// PARAMETERS
//  MAX_WAIT  8   blocked DMA cycles before a forced DMA grant; legal range 1..255 (elaboration check)
//  CNT_W     $clog2(MAX_WAIT+1)  width of the wait counter (derived; do not override)
// PORTS
//  clk         in   1   system clock, all state updates on posedge
//  rst         in   1   synchronous, active-low reset
//  cpu_req     in   1   CPU M stage holds a load or store this cycle
//  cpu_we      in   2   CPU MemWriteM: 00 none, 01 byte, 10 half, 11 word
//  cpu_addr    in   32  CPU ALUResultM
//  cpu_wdata   in   32  CPU WriteDataM
//  cpu_rdata   out  32  read data to CPU (ReadDataMTick)
//  cpu_stall   out  1   CPU must hold its M-stage request and freeze the pipeline this cycle
//  dma_valid   in   1   DMA request valid; must stay high with stable fields until dma_ready
//  dma_ready   out  1   DMA request accepted this cycle
//  dma_we      in   2   same encoding as cpu_we; 00 means read
//  dma_addr    in   32  DMA byte address
//  dma_wdata   in   32  DMA write data
//  dma_rdata   out  32  registered DMA read data
//  dma_rvalid  out  1   one-cycle pulse: dma_rdata is valid
//  mem_we      out  2   to dmem we
//  mem_addr    out  32  to dmem a
//  mem_wdata   out  32  to dmem wd
//  mem_rdata   in   32  from dmem rd (combinational read)
// BEHAVIOUR
//  - FSM states: PRI_CPU (reset state) and FORCE_DMA.
//  - grant_dma = rst & dma_valid & (~cpu_req | state==FORCE_DMA). dma_ready = grant_dma.
//  - cpu_stall = rst & cpu_req & grant_dma. With no DMA grant, the CPU is served the same cycle with no stall.
//  - Port mux: grant_dma selects dma_* for mem_we/addr/wdata. Otherwise cpu_* is selected.
//    mem_we = 00 when rst=0, or when no request is granted. mem_addr/wdata then carry cpu_* values.
//  - Timing: writes commit at the posedge of the grant cycle. cpu_rdata = mem_rdata (0-cycle latency).
//    DMA read (dma_we==00): at the grant-cycle posedge, mem_rdata is captured into dma_rdata
//    and dma_rvalid=1 for exactly the next cycle. DMA writes never pulse dma_rvalid.
//  - wait_cnt (CNT_W bits): cleared when dma_valid=0 or on a DMA handshake.
//    Increments when dma_valid & ~dma_ready, saturating at MAX_WAIT.
//  - PRI_CPU -> FORCE_DMA when wait_cnt==MAX_WAIT-1 and this cycle is blocked again.
//    The forced grant therefore occurs on the (MAX_WAIT+1)th cycle of dma_valid.
//  - FORCE_DMA -> PRI_CPU after one cycle, always (handshake made, or dma_valid dropped
//    as a protocol violation). At most one forced transfer per entry.
//  - FORCE_DMA with cpu_req=0: DMA granted, no stall, FSM returns to PRI_CPU.
//  - Back-to-back DMA requests with cpu_req=0 are accepted every cycle (throughput 1/cycle).
//  - Reset values (rst=0 at posedge): state=PRI_CPU, wait_cnt=0, dma_rdata=0, dma_rvalid=0.
//    While rst=0, combinational outputs are forced: dma_ready=0, cpu_stall=0, mem_we=00.
//    Reset between grant and rvalid cancels the pending dma_rvalid.
//  - Pipeline contract: cpu_stall freezes PC/F/D/E/M registers and injects a bubble into W.
// STRUCTURE
//  - Package dmem_arb_pkg: typedef enum logic[1:0] mem_we_t {WE_NONE, WE_BYTE, WE_HALF, WE_WORD};
//    typedef enum logic arb_state_t {PRI_CPU, FORCE_DMA}. Also used by dmem/rv32ipipelined.
//  - One sub-module dmem_arb_starve_ctr (clk, rst, inc, clr, hit): the saturating wait counter
//    plus the hit compare. Mux, FSM and read-capture stay in this module.
// TESTING
//  1. CPU only: cpu_req=1, cpu_we=11, addr=0x40, wdata=0xDEADBEEF; then a read of 0x40
//     -> mem_we=11 in cycle 0, cpu_rdata=0xDEADBEEF in cycle 1, cpu_stall=0 throughout.
//  2. DMA only: dma_valid=1, we=00, addr=0x40 -> dma_ready=1 the same cycle,
//     dma_rvalid=1 with dma_rdata=0xDEADBEEF next cycle only.
//  3. Starvation, MAX_WAIT=8: cpu_req=1 and dma_valid=1 held -> dma_ready=0 for 8 cycles.
//     Cycle 9: dma_ready=1, cpu_stall=1, mem_addr=dma_addr. Cycle 10: CPU is served, wait_cnt=0.
//  4. Simultaneous idle CPU: cpu_req=0, 4 back-to-back DMA writes to 0x100..0x10C
//     -> 4 handshakes in 4 cycles; later CPU reads return the written words.
//  5. Reset mid-read: DMA read granted, rst=0 at the next posedge -> dma_rvalid stays 0,
//     mem_we=00 and dma_ready=0 while in reset, state=PRI_CPU after release.
//  6. Protocol drop: in FORCE_DMA, dma_valid=0 -> no handshake, no stall, PRI_CPU next cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types for the data-memory port arbiter
package dmem_arb_pkg;

  // Write-enable encoding shared by the core, the DMA master and dmem.
  typedef enum logic [1:0] {
    WE_NONE = 2'b00,
    WE_BYTE = 2'b01,
    WE_HALF = 2'b10,
    WE_WORD = 2'b11
  } mem_we_t;

  // Arbiter state: normal CPU priority, or a one-cycle forced DMA slot.
  typedef enum logic {
    PRI_CPU   = 1'b0,
    FORCE_DMA = 1'b1
  } arb_state_t;

  localparam int MAX_WAIT_DEFAULT = 8;

  // A request with no write lanes enabled is a read.
  function automatic logic is_read(input logic [1:0] we);
    return we == WE_NONE;
  endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// rtl/dmem_arb_starve_ctr.sv - saturating DMA wait counter with forced-grant compare
module dmem_arb_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  // Clear has priority; otherwise count blocked cycles, holding at MAX_WAIT.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr) begin
      wait_cnt_d = '0;
    end else if (inc && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // One more blocked cycle from here reaches MAX_WAIT.
  assign hit = (wait_cnt_q == CNT_HIT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - CPU-priority dmem port arbiter with DMA starvation guard
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  localparam int CNT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [1:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_valid,
  output logic        dma_ready,
  input  logic [1:0]  dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic [1:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  if ((MAX_WAIT < 1) || (MAX_WAIT > 255)) begin : g_bad_max_wait
    $error("dmem_port_arbiter: MAX_WAIT must be in 1..255");
  end

  arb_state_t  state_q;
  arb_state_t  state_d;
  logic [31:0] dma_rdata_q;
  logic [31:0] dma_rdata_d;
  logic        dma_rvalid_q;
  logic        dma_rvalid_d;

  logic        grant_dma;
  logic        dma_blocked;
  logic        starve_hit;

  // Blocked means the DMA is asking and did not get the port this cycle.
  assign dma_blocked = dma_valid & ~grant_dma;

  dmem_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_starve_ctr (
    .clk (clk),
    .rst (rst),
    .inc (dma_blocked),
    .clr (~dma_valid | grant_dma),
    .hit (starve_hit)
  );

  // State register; reset returns to normal CPU priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= PRI_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  // Enter the forced slot on the last tolerated blocked cycle; the slot lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PRI_CPU:   if (starve_hit && dma_blocked) state_d = FORCE_DMA;
      FORCE_DMA: state_d = PRI_CPU;
      default:   state_d = PRI_CPU;
    endcase
  end

  // Grant, stall and dmem port mux; everything is quiet while in reset.
  always_comb begin
    grant_dma = rst & dma_valid & (~cpu_req | (state_q == FORCE_DMA));
    dma_ready = grant_dma;
    cpu_stall = rst & cpu_req & grant_dma;
    mem_we    = WE_NONE;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (grant_dma) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end else if (rst && cpu_req) begin
      mem_we    = cpu_we;
    end
  end

  // Capture DMA read data at the grant edge; rvalid pulses for the following cycle.
  always_comb begin
    dma_rvalid_d = grant_dma & is_read(dma_we);
    dma_rdata_d  = dma_rdata_q;
    if (dma_rvalid_d) begin
      dma_rdata_d = mem_rdata;
    end
  end

  // Read-return registers; reset also cancels a pending rvalid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;

endmodule
